ssd_scan_controller: RTL
========================

// Module: ssd_scan_controller
// PURPOSE
//   Time-multiplexed scan driver for an N-digit common-anode seven-segment display.
//   Accepts a packed hex/BCD value through a valid/ready load port.
//   Rotates one active anode per refresh slot.
//   Presents the selected nibble on `digit`, which feeds the downstream hex-to-cathode
//   decoder (digit -> g_to_a), plus the active-low decimal point.
//   New values are applied only at frame boundaries, so no digit ever shows a mix of
//   old and new values.
// PARAMETERS
//   NUM_DIGITS   4       number of display digits / anodes (>=2)
//   REFRESH_DIV  100000  clock cycles per digit slot (>=2)
//   BLANK_LZ     1       1 = blank leading zeros (digit 0 is never blanked); 0 = show all digits
// PORTS
//   clk         in   1             system clock, rising edge
//   rst_n       in   1             synchronous reset, active-low
//   en          in   1             1 = scan display; 0 = all anodes off
//   load_valid  in   1             new value offered
//   load_ready  out  1             block can accept a value
//   load_value  in   4*NUM_DIGITS  packed nibbles; [3:0] = digit 0, the rightmost (LSD)
//   load_dp     in   NUM_DIGITS    decimal-point enables, 1 = lit; bit i belongs to digit i
//   digit       out  4             nibble of the current slot, to the cathode decoder
//   anode       out  NUM_DIGITS    anode enables, active-low, one-hot-zero
//   dp_n        out  1             decimal point, active-low
//   blank       out  1             1 = no digit is driven this cycle
//   scan_tick   out  1             one-cycle pulse at the end of each slot
// BEHAVIOUR
//   Clock and reset
//   - Single clock domain. Reset is sampled only on the rising clk edge when rst_n=0.
//   - Reset values: state=IDLE, prescaler=0, index=0, disp/pend registers=0, pend_flag=0.
//     Outputs: anode = all 1s, digit=0, dp_n=1, blank=1, scan_tick=0, load_ready=1.
//   Load handshake
//   - load_ready = ~pend_flag (combinational).
//   - Transfer happens when load_valid & load_ready. On transfer, pend <= {load_value, load_dp}
//     and pend_flag <= 1.
//   - load_valid while load_ready=0 is ignored; the offer is not queued.
//   - Apply: disp <= pend and pend_flag <= 0, under either condition:
//     (a) state=IDLE, in the cycle after the transfer; or
//     (b) SCAN, on the scan_tick that ends the last slot (index=NUM_DIGITS-1).
//   - A transfer in the same cycle as a boundary tick is applied at the next boundary,
//     not the current one.
//   State machine (2 states)
//   - IDLE: prescaler and index held at 0. Outputs are dark: anode all 1s, blank=1, dp_n=1.
//     Goes to SCAN when en=1.
//   - SCAN: prescaler counts 0..REFRESH_DIV-1 and wraps.
//     scan_tick=1 in the cycle where prescaler = REFRESH_DIV-1.
//     On scan_tick, index <= (index = NUM_DIGITS-1) ? 0 : index+1.
//     Goes to IDLE in the first cycle that en=0.
//     Re-entry always starts at index 0 with prescaler 0, giving a full-length first slot.
//   Outputs (registered; they follow index/disp with 1-cycle latency)
//   - digit = disp nibble[index].
//   - dp_n = ~disp_dp[index].
//   - anode[i] = 0 only for i = index, and only if the slot is not blanked.
//   - Slot i is blanked when BLANK_LZ=1, i != 0, and every nibble i..NUM_DIGITS-1 is 0.
//     A set dp bit does not prevent blanking.
//   - A blanked slot drives anode all 1s, blank=1, dp_n=1; digit still shows the nibble.
//   - value 0 displays a single "0" in digit 0.
//   Reset mid-operation
//   - Reset discards any pending value. The next cycle's outputs equal the reset values.
// TESTING  (REFRESH_DIV=4, NUM_DIGITS=4, BLANK_LZ=1)
//   1. Reset: rst_n=0 for 2 cycles, en=1 -> anode=4'b1111, dp_n=1, blank=1, load_ready=1.
//      Release reset: anode=1110 appears 2 cycles after en is seen high.
//   2. Scan: in IDLE, load 16'h12AF with dp=4'b0100, then en=1.
//      Expect 4-cycle slots: (1110,F,dp_n=1), (1101,A,1), (1011,2,0), (0111,1,1), repeating.
//      scan_tick fires every 4th cycle.
//   3. Blanking: load 16'h0050 -> slot0 (1110,0), slot1 (1101,5), slots 2-3 anode 1111 blank=1.
//      Load 16'h0000 -> only slot0 lit, showing 0.
//   4. Mid-frame load: in slot 1, load 16'h3456 -> load_ready=0 next cycle.
//      A second offer of 16'h9999 while ready=0 is ignored.
//      Display stays old until the tick ending slot 3; next slot0 shows 6.
//      load_ready returns to 1 one cycle after the apply.
//   5. Enable: drop en mid-slot 2 -> next-but-one cycle anode=1111, blank=1.
//      Raise en -> slot0 first, held a full 4 cycles.
//   6. Reset during scan with pend_flag=1 -> reset values.
//      After release, load 16'h0001 appears; the discarded pending value never appears.

Source files
------------

// File: rtl/ssd_scan_controller_if.sv
// Load port of the seven-segment scan controller.
// A value transfers on a rising clk edge where load_valid and load_ready are
// both high. The master keeps load_value/load_dp stable while load_valid is
// high. An offer made while load_ready is low is simply not taken; it is not
// remembered.
//   load_valid  master -> slave  new value offered
//   load_ready  slave  -> master slave can accept a value
//   load_value  master -> slave  packed nibbles, [3:0] = digit 0 (rightmost)
//   load_dp     master -> slave  decimal-point enables, bit i = digit i
interface ssd_scan_controller_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      load_valid;
   logic                      load_ready;
   logic [4*NUM_DIGITS-1:0]   load_value;
   logic [NUM_DIGITS-1:0]     load_dp;

   modport master (
      output load_valid,
      output load_value,
      output load_dp,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_value,
      input  load_dp,
      output load_ready
   );
endinterface

// File: rtl/ssd_scan_controller.sv
// Time-multiplexed scan driver for an N-digit common-anode seven-segment
// display. One anode is active per refresh slot. Loaded values wait in a
// pending register and are copied to the display register only at a frame
// boundary (or straight away while idle), so a frame never mixes old and new.
// Ports:
//   clk, rst_n  clock (rising edge), synchronous active-low reset
//   en          1 = scan, 0 = all anodes off
//   load        slave side of the valid/ready load port
//   digit       nibble for the current slot, to the hex-to-cathode decoder
//   anode       active-low anode enables, at most one low
//   dp_n        active-low decimal point
//   blank       1 = no digit driven this cycle
//   scan_tick   one-cycle pulse in the last cycle of each slot
//   dbg_state   current FSM state (0 = IDLE, 1 = SCAN)
module ssd_scan_controller #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_LZ    = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   ssd_scan_controller_if.slave   load,
   output logic [3:0]             digit,
   output logic [NUM_DIGITS-1:0]  anode,
   output logic                   dp_n,
   output logic                   blank,
   output logic                   scan_tick,
   output logic                   dbg_state
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t                  state, state_nxt;
   logic [PW-1:0]           presc, presc_nxt;
   logic [IW-1:0]           index, index_nxt;
   logic [4*NUM_DIGITS-1:0] disp_value, pend_value;
   logic [NUM_DIGITS-1:0]   disp_dp, pend_dp;
   logic                    pend_flag;
   logic                    last_slot;
   logic                    transfer;
   logic                    apply;
   logic [NUM_DIGITS-1:0]   slot_blank_vec;
   logic                    zero_above;
   logic                    slot_blank;

   assign dbg_state       = state;
   assign load.load_ready = ~pend_flag;
   assign transfer        = load.load_valid & ~pend_flag;
   assign last_slot       = (index == IW'(NUM_DIGITS - 1));
   // In IDLE the pending value goes straight through; while scanning it waits
   // for the tick that closes the last slot of the frame.
   assign apply           = pend_flag & ((state == IDLE) | (scan_tick & last_slot));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         presc <= '0;
         index <= '0;
      end else begin
         state <= state_nxt;
         presc <= presc_nxt;
         index <= index_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      presc_nxt = presc;
      index_nxt = index;
      scan_tick = 1'b0;
      case (state)
         IDLE: begin
            presc_nxt = '0;
            index_nxt = '0;
            if (en) state_nxt = SCAN;
         end
         SCAN: begin
            if (presc == PW'(REFRESH_DIV - 1)) begin
               scan_tick = 1'b1;
               presc_nxt = '0;
               index_nxt = last_slot ? '0 : index + 1'b1;
            end else begin
               presc_nxt = presc + 1'b1;
            end
            // Leaving SCAN clears the counters so re-entry gets a full slot 0.
            if (!en) begin
               state_nxt = IDLE;
               presc_nxt = '0;
               index_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pending / display registers. transfer needs pend_flag=0 and apply needs
   // pend_flag=1, so the two never coincide.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_value <= '0;
         pend_dp    <= '0;
         pend_flag  <= 1'b0;
         disp_value <= '0;
         disp_dp    <= '0;
      end else if (apply) begin
         disp_value <= pend_value;
         disp_dp    <= pend_dp;
         pend_flag  <= 1'b0;
      end else if (transfer) begin
         pend_value <= load.load_value;
         pend_dp    <= load.load_dp;
         pend_flag  <= 1'b1;
      end
   end

   // Slot i is a leading zero when it and every more-significant nibble are 0.
   // Digit 0 always shows, so a value of 0 displays a single "0".
   always_comb begin
      zero_above     = 1'b1;
      slot_blank_vec = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above        = zero_above & (disp_value[4*i +: 4] == 4'd0);
         slot_blank_vec[i] = (BLANK_LZ != 0) && (i != 0) && zero_above;
      end
   end

   assign slot_blank = slot_blank_vec[index];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         digit <= 4'd0;
         anode <= '1;
         dp_n  <= 1'b1;
         blank <= 1'b1;
      end else begin
         digit <= disp_value[{index, 2'b00} +: 4];
         if (state == SCAN && !slot_blank) begin
            anode <= ~(NUM_DIGITS'(1) << index);
            dp_n  <= ~disp_dp[index];
            blank <= 1'b0;
         end else begin
            anode <= '1;
            dp_n  <= 1'b1;
            blank <= 1'b1;
         end
      end
   end

endmodule
